rob_queue: RTL

Reorder buffer for the out-of-order core: allocates one entry per dispatched instruction in program order, captures results broadcast on the CDB, and retires completed entries in order. Sits between decode/dispatch and the architectural register file. Drives the regfile write-back port (`load_reg_wb`, `regidx_wb`, `regdata_wb`) that the RVFI monitor observes as commit. Raises a pipeline flush when a mispredicted branch retires.

---
 rtl/rob_pkg.sv | 17 +
 rtl/rob_ptr.sv | 16 +
 rtl/rob_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer.
package rob_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_XLEN  = 32;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int ROB_CNT_W = ROB_TAG_W + 1;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                mispredict;
    logic [4:0]          rd;
    logic [31:0]         inst;
    logic [ROB_XLEN-1:0] data;
    logic [ROB_XLEN-1:0] target;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer; W bits wrap naturally because depth is a power of two.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/rob_queue.sv
// In-order-retire reorder buffer with CDB capture and mispredict flush.
// Optional ROB_COMMIT_ORDER_EN adds a 64-bit retirement sequence counter.
module rob_queue
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int XLEN  = ROB_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic [4:0]               alloc_rd,
  input  logic [31:0]              alloc_inst,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     cdb_valid,
  input  logic [$clog2(DEPTH)-1:0] cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  input  logic                     cdb_mispredict,
  input  logic [XLEN-1:0]          cdb_target,
  input  logic [$clog2(DEPTH)-1:0] src_tag,
  output logic                     src_ready,
  output logic [XLEN-1:0]          src_data,
  output logic                     load_reg_wb,
  output logic [4:0]               regidx_wb,
  output logic [XLEN-1:0]          regdata_wb,
  output logic                     commit_valid,
  output logic [31:0]              commit_inst,
  output logic                     flush,
  output logic [XLEN-1:0]          flush_pc,
  output logic                     rob_empty
`ifdef ROB_COMMIT_ORDER_EN
  ,output logic [63:0]             commit_order
`endif
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  rob_entry_t [DEPTH-1:0] ents;
  rob_entry_t             head_e;
  logic [TAG_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count;
  logic                   alloc_fire;

  assign head_e       = ents[head];
  assign commit_valid = head_e.valid && head_e.done;
  assign flush        = commit_valid && head_e.mispredict;
  assign flush_pc     = head_e.target;
  assign load_reg_wb  = commit_valid && (head_e.rd != 5'd0) && !head_e.mispredict;
  assign regidx_wb    = head_e.rd;
  assign regdata_wb   = head_e.data;
  assign commit_inst  = head_e.inst;

  // Readiness is from count alone, so a full ROB stalls even while retiring.
  assign alloc_ready = (count != CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign alloc_tag   = tail;
  assign rob_empty   = (count == '0);

  assign src_ready = ents[src_tag].valid && ents[src_tag].done;
  assign src_data  = ents[src_tag].data;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk(clk), .rst_n(rst), .inc(commit_valid), .clr(flush), .ptr(head)
  );
  rob_ptr #(.W(TAG_W)) u_tail (
    .clk(clk), .rst_n(rst), .inc(alloc_fire), .clr(flush), .ptr(tail)
  );

  // Commit clear is last so it wins over any stray write to the head slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ents <= '0;
    end else if (flush) begin
      ents <= '0;
    end else begin
      if (alloc_fire)
        ents[tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0, rd: alloc_rd,
                        inst: alloc_inst, data: '0, target: '0};
      if (cdb_valid && ents[cdb_tag].valid) begin
        ents[cdb_tag].done       <= 1'b1;
        ents[cdb_tag].data       <= cdb_data;
        ents[cdb_tag].mispredict <= cdb_mispredict;
        ents[cdb_tag].target     <= cdb_target;
      end
      if (commit_valid) ents[head] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= '0;
    else if (flush) count <= '0;
    else begin
      case ({alloc_fire, commit_valid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ROB_COMMIT_ORDER_EN
  // Counts every retirement, the flushing branch included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              commit_order <= '0;
    else if (commit_valid) commit_order <= commit_order + 64'd1;
  end
`else
  // Retirement order counter not built.
`endif
endmodule
